// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
//   Shared definitions for the two-master Wishbone arbiter slice:
//   bus widths (32/32) and the arbiter state type.
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

  localparam int unsigned WB_ADR_WIDTH = 32;
  localparam int unsigned WB_DAT_WIDTH = 32;
  localparam int unsigned WB_SEL_WIDTH = WB_DAT_WIDTH / 8;

  // Bus ownership state
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_watchdog
//   Counts cycles of an unacknowledged strobe and forces an error once the
//   count reaches TIMEOUT_CYCLES (0 disables). On the timeout cycle the
//   strobe towards the slave is masked and a late ack is ignored by the
//   caller via timeout_o.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   stb_i          strobe as routed from the owning master
//   ack_i, err_i   slave termination
//   owner_chg_i    bus ownership changes at the next edge
//   timeout_o      forced-error pulse (same cycle as wd == TIMEOUT_CYCLES)
//   stb_o          strobe to the slave, masked during timeout
// ---------------------------------------------------------------------------
module wb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic stb_i,
   input  logic ack_i,
   input  logic err_i,
   input  logic owner_chg_i,
   output logic timeout_o,
   output logic stb_o
);

   localparam logic [15:0] LIMIT   = 16'(TIMEOUT_CYCLES);
   localparam bit          ENABLED = (TIMEOUT_CYCLES != 0);

   logic [15:0] wd_q;

   assign timeout_o = ENABLED && stb_i && (wd_q == LIMIT);
   assign stb_o     = stb_i & ~timeout_o;

   always_ff @(posedge clk_i) begin
      if (rst_i || owner_chg_i || !stb_i || ack_i || err_i || timeout_o) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + 16'd1;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Two-master Wishbone classic arbiter with round-robin tie break and a
//   bus lock held for as long as the owner keeps cyc asserted. A watchdog
//   terminates strobes the slave never answers with an error.
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   m0_* / m1_*           master-side buses (cyc, stb, we, sel, adr, dat in;
//                         dat, ack, err out)
//   s_*_o                 slave-side bus towards the address decoder
//   s_dat_i, s_ack_i,
//   s_err_i               slave read data and termination
// ---------------------------------------------------------------------------
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // master 0
   input  logic                    m0_cyc_i,
   input  logic                    m0_stb_i,
   input  logic                    m0_we_i,
   input  logic [WB_SEL_WIDTH-1:0] m0_sel_i,
   input  logic [WB_ADR_WIDTH-1:0] m0_adr_i,
   input  logic [WB_DAT_WIDTH-1:0] m0_dat_i,
   output logic [WB_DAT_WIDTH-1:0] m0_dat_o,
   output logic                    m0_ack_o,
   output logic                    m0_err_o,
   // master 1
   input  logic                    m1_cyc_i,
   input  logic                    m1_stb_i,
   input  logic                    m1_we_i,
   input  logic [WB_SEL_WIDTH-1:0] m1_sel_i,
   input  logic [WB_ADR_WIDTH-1:0] m1_adr_i,
   input  logic [WB_DAT_WIDTH-1:0] m1_dat_i,
   output logic [WB_DAT_WIDTH-1:0] m1_dat_o,
   output logic                    m1_ack_o,
   output logic                    m1_err_o,
   // slave side
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic                    s_we_o,
   output logic [WB_SEL_WIDTH-1:0] s_sel_o,
   output logic [WB_ADR_WIDTH-1:0] s_adr_o,
   output logic [WB_DAT_WIDTH-1:0] s_dat_o,
   input  logic [WB_DAT_WIDTH-1:0] s_dat_i,
   input  logic                    s_ack_i,
   input  logic                    s_err_i
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       own0, own1;
   logic       raw_stb;
   logic       timeout;
   logic       term_ack, term_err;

   // ---------------- state register ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ARB_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? ARB_OWN0 : ARB_OWN1;
            end else if (m0_cyc_i) begin
               state_d = ARB_OWN0;
            end else if (m1_cyc_i) begin
               state_d = ARB_OWN1;
            end
         end
         ARB_OWN0: begin
            if (!m0_cyc_i) begin
               last_d  = 1'b0;
               state_d = m1_cyc_i ? ARB_OWN1 : ARB_IDLE;
            end
         end
         ARB_OWN1: begin
            if (!m1_cyc_i) begin
               last_d  = 1'b1;
               state_d = m0_cyc_i ? ARB_OWN0 : ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Reset overrides routing combinationally so nothing leaks out while
   // rst_i is high, even before the state register has been cleared.
   assign own0 = (state_q == ARB_OWN0) && !rst_i;
   assign own1 = (state_q == ARB_OWN1) && !rst_i;

   // ---------------- watchdog ----------------
   wb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .stb_i       (raw_stb),
      .ack_i       (s_ack_i),
      .err_i       (s_err_i),
      .owner_chg_i (state_d != state_q),
      .timeout_o   (timeout),
      .stb_o       (s_stb_o)
   );

   // err beats ack; a timeout swallows any late ack on the same cycle
   assign term_ack = s_ack_i & ~s_err_i & ~timeout;
   assign term_err = s_err_i | timeout;

   // ---------------- routing ----------------
   always_comb begin
      raw_stb  = 1'b0;
      s_cyc_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      if (own0) begin
         s_cyc_o  = m0_cyc_i;
         raw_stb  = m0_stb_i;
         s_we_o   = m0_we_i;
         s_sel_o  = m0_sel_i;
         s_adr_o  = m0_adr_i;
         s_dat_o  = m0_dat_i;
         m0_dat_o = s_dat_i;
         m0_ack_o = term_ack;
         m0_err_o = term_err;
      end else if (own1) begin
         s_cyc_o  = m1_cyc_i;
         raw_stb  = m1_stb_i;
         s_we_o   = m1_we_i;
         s_sel_o  = m1_sel_i;
         s_adr_o  = m1_adr_i;
         s_dat_o  = m1_dat_i;
         m1_dat_o = s_dat_i;
         m1_ack_o = term_ack;
         m1_err_o = term_err;
      end
   end

endmodule
